// File: rtl/zeroriscy_lsu_nb.sv
// zeroriscy_lsu_nb: non-blocking load/store unit between EX and the data bus.
// Keeps up to MAX_OUTST bus beats in flight and splits misaligned word and
// half-word accesses into two aligned beats. Results return to EX in request
// order, one lsu_rvalid_o per access.
//
// Optional feature: define ZERORISCY_LSU_BUS_ERR_EN to report bus errors
// (lsu_err_o) together with the original byte address (lsu_err_addr_o).
// Without it, data_err_i is ignored and both error outputs are tied to 0.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   lsu_req_i / lsu_gnt_o     EX request / access fully issued
//   lsu_we_i, lsu_type_i,
//   lsu_sign_ext_i,
//   lsu_addr_i, lsu_wdata_i   access attributes, held until lsu_gnt_o
//   lsu_rvalid_o, lsu_rdata_o completed access and its extended load data
//   lsu_err_o, lsu_err_addr_o bus error and faulting original address
//   busy_o                    beats outstanding or a bus request pending
//   data_req_o / data_gnt_i   bus request / grant
//   data_addr_o, data_we_o,
//   data_be_o, data_wdata_o   bus beat attributes (word-aligned)
//   data_rvalid_i, data_err_i,
//   data_rdata_i              in-order bus response
module zeroriscy_lsu_nb #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_req_i,
    output logic              lsu_gnt_o,
    input  logic              lsu_we_i,
    input  logic [1:0]        lsu_type_i,
    input  logic              lsu_sign_ext_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [31:0]       lsu_wdata_i,
    output logic              lsu_rvalid_o,
    output logic [31:0]       lsu_rdata_o,
    output logic              lsu_err_o,
    output logic [ADDR_W-1:0] lsu_err_addr_o,
    output logic              busy_o,
    output logic              data_req_o,
    input  logic              data_gnt_i,
    input  logic              data_rvalid_i,
    input  logic              data_err_i,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic              data_we_o,
    output logic [3:0]        data_be_o,
    output logic [31:0]       data_wdata_o,
    input  logic [31:0]       data_rdata_i
);

    localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

    typedef enum logic {
        ST_ISSUE,
        ST_SECOND
    } state_e;

    typedef enum logic [1:0] {
        PART_SINGLE = 2'd0,
        PART_FIRST  = 2'd1,
        PART_SECOND = 2'd2
    } part_e;

    // Per-beat bookkeeping needed to rebuild the EX result on response.
    typedef struct packed {
        logic              we;
        logic [1:0]        typ;
        logic [1:0]        off;
        logic              sign_ext;
        part_e             part;
`ifdef ZERORISCY_LSU_BUS_ERR_EN
        logic [ADDR_W-1:0] addr;
`endif
    } meta_t;

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    meta_t             meta_q [MAX_OUTST];
    meta_t             push_meta;
    meta_t             head;
    logic [31:0]       stage_data_q;

    logic              can_issue;
    logic              misaligned;
    logic              second_beat;
    part_e             beat_part;
    logic              push;
    logic              pop;

    logic [1:0]        off;
    logic [3:0]        be_base;
    logic [7:0]        be_wide;
    logic [ADDR_W-1:0] addr_aligned;
    logic [4:0]        lane_sh;

    logic [31:0]       single_sh;
    logic [31:0]       split_sh;
    logic [31:0]       raw_data;
    logic [31:0]       ext_data;
    logic [4:0]        resp_sh;

    // Request-side decode
    assign off          = lsu_addr_i[1:0];
    assign lane_sh      = {off, 3'b000};
    assign addr_aligned = {lsu_addr_i[ADDR_W-1:2], 2'b00};
    assign can_issue    = (cnt_q < CNT_W'(MAX_OUTST));

    always_comb begin
        misaligned = 1'b0;
        unique case (lsu_type_i)
            2'b00:   misaligned = (off != 2'b00);
            2'b01:   misaligned = (off == 2'b11);
            default: misaligned = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ISSUE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ISSUE: begin
                if (lsu_req_i && can_issue && data_gnt_i && misaligned) begin
                    state_d = ST_SECOND;
                end
            end
            ST_SECOND: begin
                if (can_issue && data_gnt_i) begin
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_ISSUE;
        endcase
    end

    // FSM outputs: bus request, EX grant and which part of the access is issued
    always_comb begin
        data_req_o  = 1'b0;
        lsu_gnt_o   = 1'b0;
        second_beat = 1'b0;
        beat_part   = PART_SINGLE;
        unique case (state_q)
            ST_ISSUE: begin
                data_req_o = lsu_req_i && can_issue;
                lsu_gnt_o  = data_req_o && data_gnt_i && !misaligned;
                beat_part  = misaligned ? PART_FIRST : PART_SINGLE;
            end
            ST_SECOND: begin
                data_req_o  = can_issue;
                lsu_gnt_o   = can_issue && data_gnt_i;
                second_beat = 1'b1;
                beat_part   = PART_SECOND;
            end
            default: begin
                data_req_o = 1'b0;
            end
        endcase
    end

    // Bus beat attributes; the second beat takes the lanes that spill past
    // the first word, so both come from one 8-lane shifted mask.
    always_comb begin
        be_base = 4'b0001;
        unique case (lsu_type_i)
            2'b00:   be_base = 4'b1111;
            2'b01:   be_base = 4'b0011;
            default: be_base = 4'b0001;
        endcase
        be_wide = {4'b0000, be_base} << off;

        data_addr_o  = '0;
        data_we_o    = 1'b0;
        data_be_o    = 4'b0000;
        data_wdata_o = '0;
        if (data_req_o) begin
            data_addr_o  = second_beat ? (addr_aligned + ADDR_W'(4)) : addr_aligned;
            data_we_o    = lsu_we_i;
            data_be_o    = second_beat ? be_wide[7:4] : be_wide[3:0];
            // Rotate left so every byte lands in its lane on either beat.
            data_wdata_o = (lsu_wdata_i << lane_sh) |
                           (lsu_wdata_i >> (6'd32 - {1'b0, lane_sh}));
        end
    end

    // Metadata FIFO: one entry per granted beat, popped per bus response
    assign push = data_req_o && data_gnt_i;
    assign pop  = data_rvalid_i && (cnt_q != '0);

    always_comb begin
        push_meta          = '0;
        push_meta.we       = lsu_we_i;
        push_meta.typ      = lsu_type_i;
        push_meta.off      = off;
        push_meta.sign_ext = lsu_sign_ext_i;
        push_meta.part     = beat_part;
`ifdef ZERORISCY_LSU_BUS_ERR_EN
        push_meta.addr     = lsu_addr_i;
`endif
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : (p + PTR_W'(1));
    endfunction

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // FIFO storage; entries are only read while valid, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            meta_q[wr_ptr_q] <= push_meta;
        end
    end

    assign head = meta_q[rd_ptr_q];

    // Staging register for the first half of a split access
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_data_q <= '0;
        end else if (pop && (head.part == PART_FIRST)) begin
            stage_data_q <= data_rdata_i;
        end
    end

    // Response extraction: shift the addressed bytes down, then extend
    assign resp_sh   = {head.off, 3'b000};
    assign single_sh = data_rdata_i >> resp_sh;
    assign split_sh  = 32'({data_rdata_i, stage_data_q} >> resp_sh);
    assign raw_data  = (head.part == PART_SECOND) ? split_sh : single_sh;

    always_comb begin
        ext_data = raw_data;
        unique case (head.typ)
            2'b00:   ext_data = raw_data;
            2'b01:   ext_data = {{16{head.sign_ext & raw_data[15]}}, raw_data[15:0]};
            default: ext_data = {{24{head.sign_ext & raw_data[7]}}, raw_data[7:0]};
        endcase
    end

    assign lsu_rvalid_o = pop && (head.part != PART_FIRST);
    assign lsu_rdata_o  = (lsu_rvalid_o && !head.we) ? ext_data : 32'h0;
    assign busy_o       = (cnt_q != '0) || data_req_o;

`ifdef ZERORISCY_LSU_BUS_ERR_EN
    logic stage_err_q;

    // Error bit of the first beat travels with the staged data
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_err_q <= 1'b0;
        end else if (pop && (head.part == PART_FIRST)) begin
            stage_err_q <= data_err_i;
        end
    end

    assign lsu_err_o      = lsu_rvalid_o &&
                            (data_err_i || ((head.part == PART_SECOND) && stage_err_q));
    assign lsu_err_addr_o = lsu_err_o ? head.addr : '0;
`else
    logic unused_data_err;

    assign unused_data_err = data_err_i;
    assign lsu_err_o       = 1'b0;
    assign lsu_err_addr_o  = '0;
`endif

endmodule

// File: tb/tb_zeroriscy_lsu_nb.sv
// Scoreboard bench for zeroriscy_lsu_nb: EX accesses are queued, each expected
// result is pushed when its request is first driven and popped when the DUT
// returns lsu_rvalid_o. A bus responder model answers beats in order with
// programmable grant probability and response delay.
module tb_zeroriscy_lsu_nb;

    localparam int unsigned MAX_OUTST = 2;
`ifdef ZERORISCY_LSU_BUS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_req_i = 1'b0;
    logic        lsu_gnt_o;
    logic        lsu_we_i = 1'b0;
    logic [1:0]  lsu_type_i = 2'b00;
    logic        lsu_sign_ext_i = 1'b0;
    logic [31:0] lsu_addr_i = '0;
    logic [31:0] lsu_wdata_i = '0;
    logic        lsu_rvalid_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_err_o;
    logic [31:0] lsu_err_addr_o;
    logic        busy_o;
    logic        data_req_o;
    logic        data_gnt_i = 1'b0;
    logic        data_rvalid_i = 1'b0;
    logic        data_err_i = 1'b0;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i = '0;

    always #5 clk = ~clk;

    zeroriscy_lsu_nb #(.ADDR_W(32), .MAX_OUTST(MAX_OUTST)) dut (
        .clk(clk), .rst(rst),
        .lsu_req_i(lsu_req_i), .lsu_gnt_o(lsu_gnt_o), .lsu_we_i(lsu_we_i),
        .lsu_type_i(lsu_type_i), .lsu_sign_ext_i(lsu_sign_ext_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
        .lsu_err_o(lsu_err_o), .lsu_err_addr_o(lsu_err_addr_o), .busy_o(busy_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
        .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i),
        .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i)
    );

    typedef struct {
        bit        we;
        bit [1:0]  typ;
        bit        sx;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit        e1;
        bit        e2;
    } acc_t;

    typedef struct {
        bit [31:0] rdata;
        bit        err;
        bit [31:0] eaddr;
    } exp_t;

    typedef struct {
        bit [31:0] addr;
        bit        err;
        bit        last;
        bit        stale;
        int        due;
    } beat_t;

    acc_t  acc_q[$];
    exp_t  exp_q[$];
    beat_t bq[$];
    acc_t  cur;
    bit    cur_valid = 1'b0;
    int    beat_idx = 0;
    int    cyc = 0;
    int    last_due = 0;
    int    gnt_pct = 100;
    int    dly_min = 0;
    int    dly_max = 0;
    int    gap_pct = 0;
    bit    rst_now = 1'b1;
    int    n_checks = 0;
    int    n_errors = 0;

    int        gnt_cyc, rv_cyc, first_beat_cyc, cur_first_cyc;
    int        grants_before_rv, full_cycles;
    bit        seen_rv;
    bit [31:0] last_rdata;
    bit        last_err;
    bit [31:0] last_eaddr;
    bit [31:0] log_addr[$];
    bit [3:0]  log_be[$];
    bit [31:0] log_wdata[$];
    bit [7:0]  mem_ovr [bit [31:0]];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic bit [7:0] mem_byte(input bit [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return 8'((a * 32'd2654435761) >> 13);
    endfunction

    function automatic bit [31:0] mem_word(input bit [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    function automatic int nbytes(input bit [1:0] t);
        return t[1] ? 1 : (t[0] ? 2 : 4);
    endfunction

    function automatic bit is_split(input acc_t a);
        int n = nbytes(a.typ);
        if (n == 4) return a.addr[1:0] != 2'b00;
        if (n == 2) return a.addr[1:0] == 2'b11;
        return 1'b0;
    endfunction

    // Reference result built byte by byte from the memory model
    function automatic exp_t model(input acc_t a);
        exp_t      e;
        bit [31:0] v = '0;
        int        n = nbytes(a.typ);
        for (int k = 0; k < n; k++) v |= 32'(mem_byte(a.addr + 32'(k))) << (8 * k);
        if (a.sx && n == 1 && v[7])  v |= 32'hFFFF_FF00;
        if (a.sx && n == 2 && v[15]) v |= 32'hFFFF_0000;
        if (a.we) v = '0;
        e.rdata = v;
        e.err   = ERR_EN && (a.e1 || (is_split(a) && a.e2));
        e.eaddr = e.err ? a.addr : 32'h0;
        return e;
    endfunction

    function automatic bit [31:0] beat_addr(input acc_t a, input int k);
        return {a.addr[31:2], 2'b00} + 32'(4 * k);
    endfunction

    function automatic bit [3:0] exp_be(input acc_t a, input int k);
        bit [31:0] d;
        bit [3:0]  be = '0;
        for (int i = 0; i < 4; i++) begin
            d     = beat_addr(a, k) + 32'(i) - a.addr;
            be[i] = d < 32'(nbytes(a.typ));
        end
        return be;
    endfunction

    function automatic bit [31:0] exp_wdata(input acc_t a);
        bit [31:0] w;
        int        src;
        for (int i = 0; i < 4; i++) begin
            src          = (i - int'(a.addr[1:0])) & 3;
            w[8*i +: 8]  = a.wdata[8*src +: 8];
        end
        return w;
    endfunction

    function automatic acc_t mk(input bit we, input bit [1:0] typ, input bit sx,
                                input bit [31:0] addr, input bit [31:0] wdata,
                                input bit e1, input bit e2);
        acc_t a;
        a.we = we; a.typ = typ; a.sx = sx; a.addr = addr; a.wdata = wdata;
        a.e1 = e1; a.e2 = e2;
        return a;
    endfunction

    // One clock: drive at +2, sample at +4, update models
    task automatic step();
        beat_t b;
        exp_t  e;
        bit    resp_now, grant, exp_req, is_last;
        int    live, d;
        @(posedge clk);
        #2;
        cyc++;
        rst = rst_now;
        if (rst_now) cur_valid = 1'b0;
        if (!cur_valid && !rst_now && acc_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
            cur       = acc_q.pop_front();
            cur_valid = 1'b1;
            beat_idx  = 0;
            exp_q.push_back(model(cur));
        end
        lsu_req_i      = cur_valid;
        lsu_we_i       = cur.we;
        lsu_type_i     = cur.typ;
        lsu_sign_ext_i = cur.sx;
        lsu_addr_i     = cur.addr;
        lsu_wdata_i    = cur.wdata;
        data_gnt_i     = $urandom_range(99) < gnt_pct;
        resp_now       = bq.size() > 0 && bq[0].due <= cyc;
        data_rvalid_i  = resp_now;
        data_rdata_i   = resp_now ? mem_word(bq[0].addr) : $urandom();
        data_err_i     = resp_now ? bq[0].err : 1'($urandom_range(1));
        #2;
        if (rst_now) begin
            if (resp_now) void'(bq.pop_front());
            return;
        end
        live = 0;
        foreach (bq[i]) if (!bq[i].stale) live++;
        exp_req = cur_valid && (live < MAX_OUTST);
        if (cur_valid && live == MAX_OUTST) full_cycles++;
        check("data_req", data_req_o, exp_req);
        check("busy", busy_o, (live != 0) || exp_req);
        grant   = data_req_o && data_gnt_i && cur_valid;
        is_last = (beat_idx == 1) || !is_split(cur);
        check("lsu_gnt", lsu_gnt_o, grant && is_last);
        if (grant) begin
            check("bus_addr", data_addr_o, beat_addr(cur, beat_idx));
            check("bus_be", data_be_o, exp_be(cur, beat_idx));
            check("bus_we", data_we_o, cur.we);
            if (cur.we) check("bus_wdata", data_wdata_o, exp_wdata(cur));
            log_addr.push_back(data_addr_o);
            log_be.push_back(data_be_o);
            log_wdata.push_back(data_wdata_o);
        end
        if (resp_now) begin
            b = bq.pop_front();
            if (b.stale) begin
                check("stale_rvalid", lsu_rvalid_o, 1'b0);
            end else begin
                check("rvalid", lsu_rvalid_o, b.last);
                if (b.last) begin
                    if (exp_q.size() == 0) begin
                        check("sb_empty", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("rdata", lsu_rdata_o, e.rdata);
                        check("err", lsu_err_o, e.err);
                        check("err_addr", lsu_err_addr_o, e.eaddr);
                    end
                    last_rdata = lsu_rdata_o;
                    last_err   = lsu_err_o;
                    last_eaddr = lsu_err_addr_o;
                    rv_cyc     = cyc;
                    seen_rv    = 1'b1;
                end
            end
        end else begin
            check("rvalid_idle", lsu_rvalid_o, 1'b0);
        end
        if (grant) begin
            d       = $urandom_range(dly_max, dly_min);
            b.addr  = beat_addr(cur, beat_idx);
            b.err   = (beat_idx == 1) ? cur.e2 : cur.e1;
            b.last  = is_last;
            b.stale = 1'b0;
            b.due   = (cyc + 1 + d > last_due + 1) ? cyc + 1 + d : last_due + 1;
            last_due = b.due;
            bq.push_back(b);
            if (!seen_rv) grants_before_rv++;
            if (beat_idx == 0) cur_first_cyc = cyc;
            if (is_last) begin
                cur_valid      = 1'b0;
                gnt_cyc        = cyc;
                first_beat_cyc = cur_first_cyc;
            end else begin
                beat_idx = 1;
            end
        end
    endtask

    task automatic do_reset(input int n);
        rst_now = 1'b1;
        for (int i = 0; i < n; i++) step();
        rst_now = 1'b0;
        foreach (bq[i]) bq[i].stale = 1'b1;
        exp_q.delete();
    endtask

    task automatic run_idle(input int budget);
        int i = 0;
        while ((acc_q.size() > 0 || cur_valid || bq.size() > 0) && i < budget) begin
            step();
            i++;
        end
        check("drain_timeout", 64'(acc_q.size() + bq.size() + int'(cur_valid)), 64'd0);
    endtask

    task automatic new_phase(input int gp, input int dmin, input int dmax, input int gap);
        gnt_pct = gp; dly_min = dmin; dly_max = dmax; gap_pct = gap;
        log_addr.delete(); log_be.delete(); log_wdata.delete();
        seen_rv = 1'b0; grants_before_rv = 0; full_cycles = 0;
    endtask

    initial begin
        acc_t a;
        cur = mk(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        do_reset(3);
        step();
        check("rst_gnt", lsu_gnt_o, 1'b0);
        check("rst_be", data_be_o, 4'b0000);
        check("rst_addr", data_addr_o, 32'h0);
        check("rst_rdata", lsu_rdata_o, 32'h0);
        check("rst_err", lsu_err_o, 1'b0);
        check("rst_err_addr", lsu_err_addr_o, 32'h0);

        // Aligned LW: grant in N, result in N+1
        mem_ovr[32'h100] = 8'hEF; mem_ovr[32'h101] = 8'hBE;
        mem_ovr[32'h102] = 8'hAD; mem_ovr[32'h103] = 8'hDE;
        new_phase(100, 0, 0, 0);
        acc_q.push_back(mk(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0));
        run_idle(50);
        check("lw_rdata", last_rdata, 32'hDEAD_BEEF);
        check("lw_latency", 64'(rv_cyc - gnt_cyc), 64'd1);
        check("lw_be", log_be[0], 4'b1111);

        // Misaligned LH with sign extension across two words
        mem_ovr[32'h103] = 8'h80; mem_ovr[32'h104] = 8'hFF;
        new_phase(100, 0, 0, 0);
        acc_q.push_back(mk(1'b0, 2'b01, 1'b1, 32'h103, 32'h0, 1'b0, 1'b0));
        run_idle(50);
        check("lh_rdata", last_rdata, 32'hFFFF_FF80);
        check("lh_addr0", log_addr[0], 32'h100);
        check("lh_addr1", log_addr[1], 32'h104);
        check("lh_be0", log_be[0], 4'b1000);
        check("lh_be1", log_be[1], 4'b0001);
        check("lh_gnt_gap", 64'(gnt_cyc - first_beat_cyc), 64'd1);
        check("lh_latency", 64'(rv_cyc - gnt_cyc), 64'd1);

        // Misaligned SW: rotated data on both beats
        new_phase(100, 0, 1, 0);
        acc_q.push_back(mk(1'b1, 2'b00, 1'b0, 32'h202, 32'h1122_3344, 1'b0, 1'b0));
        run_idle(50);
        check("sw_addr0", log_addr[0], 32'h200);
        check("sw_addr1", log_addr[1], 32'h204);
        check("sw_be0", log_be[0], 4'b1100);
        check("sw_be1", log_be[1], 4'b0011);
        check("sw_wdata0", log_wdata[0], 32'h3344_1122);
        check("sw_wdata1", log_wdata[1], 32'h3344_1122);

        // Four back-to-back LBs with slow responses fill the FIFO
        new_phase(100, 3, 3, 0);
        for (int i = 0; i < 4; i++)
            acc_q.push_back(mk(1'b0, 2'b10, 1'(i), 32'h400 + 32'(i), 32'h0, 1'b0, 1'b0));
        run_idle(100);
        check("lb_grants_before_rv", 64'(grants_before_rv), 64'(MAX_OUTST));
        check("lb_full_seen", 64'(full_cycles > 0), 64'd1);

        // Misaligned LW with an error on the first beat only
        new_phase(100, 0, 2, 0);
        acc_q.push_back(mk(1'b0, 2'b00, 1'b0, 32'h301, 32'h0, 1'b1, 1'b0));
        run_idle(50);
        check("err_flag", last_err, ERR_EN);
        check("err_addr_val", last_eaddr, ERR_EN ? 32'h301 : 32'h0);

        // Split access wrapping past the top of the address space
        new_phase(100, 0, 0, 0);
        acc_q.push_back(mk(1'b0, 2'b00, 1'b0, 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0));
        run_idle(50);
        check("wrap_addr0", log_addr[0], 32'hFFFF_FFFC);
        check("wrap_addr1", log_addr[1], 32'h0000_0000);

        // Random mix of loads/stores, stalls, delays and errors
        new_phase(70, 0, 3, 20);
        for (int i = 0; i < 60; i++) begin
            a = mk(1'($urandom_range(1)), 2'($urandom_range(3)), 1'($urandom_range(1)),
                   32'($urandom_range(4095)), $urandom(),
                   $urandom_range(99) < 15, $urandom_range(99) < 15);
            acc_q.push_back(a);
        end
        run_idle(2000);

        // Reset with two beats outstanding; late responses must be dropped
        new_phase(100, 8, 8, 0);
        acc_q.push_back(mk(1'b0, 2'b00, 1'b0, 32'h500, 32'h0, 1'b0, 1'b0));
        acc_q.push_back(mk(1'b0, 2'b00, 1'b0, 32'h504, 32'h0, 1'b0, 1'b0));
        for (int i = 0; i < 20 && bq.size() < 2; i++) step();
        check("rst_outstanding", 64'(bq.size()), 64'd2);
        do_reset(2);
        run_idle(50);

        // Reset in the middle of a split, then the access is re-requested
        new_phase(100, 0, 0, 0);
        a = mk(1'b0, 2'b00, 1'b1, 32'h603, 32'h0, 1'b0, 1'b0);
        acc_q.push_back(a);
        for (int i = 0; i < 20 && !(cur_valid && beat_idx == 1); i++) step();
        check("split_pending", 64'(beat_idx), 64'd1);
        do_reset(1);
        run_idle(50);
        new_phase(100, 0, 1, 0);
        acc_q.push_back(a);
        acc_q.push_back(mk(1'b0, 2'b01, 1'b1, 32'h606, 32'h0, 1'b0, 1'b0));
        run_idle(50);
        check("post_rst_rdata", last_rdata, model(acc_q.size() == 0 ?
              mk(1'b0, 2'b01, 1'b1, 32'h606, 32'h0, 1'b0, 1'b0) : a).rdata);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/zeroriscy_lsu_nb.md
# zeroriscy_lsu_nb

Non-blocking load/store unit for the zero-riscy core. It sits between the EX stage and the data memory bus, and keeps up to `MAX_OUTST` bus transactions in flight. It splits misaligned word and half-word accesses into two aligned bus beats and returns results to EX in request order. With error reporting compiled in, it also reports bus errors together with the faulting address.

## Interface
Parameters:
- `ADDR_W`, 32: address width; the data width is fixed at 32.
- `MAX_OUTST`, 2: maximum number of granted-but-unanswered bus beats; power of 2, range 1..8.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `lsu_req_i` in 1: EX access request; the `lsu_*_i` fields are held stable until `lsu_gnt_o`.
- `lsu_gnt_o` out 1: access fully issued; the EX request is consumed this cycle.
- `lsu_we_i` in 1: 1 = store.
- `lsu_type_i` in 2: 00 word, 01 half, 1x byte.
- `lsu_sign_ext_i` in 1: sign-extend load result.
- `lsu_addr_i` in ADDR_W: byte address.
- `lsu_wdata_i` in 32: store data, LSB-justified.
- `lsu_rvalid_o` out 1: one completed access (load or store).
- `lsu_rdata_o` out 32: extended load data; 0 for stores.
- `lsu_err_o` out 1: completed access had a bus error.
- `lsu_err_addr_o` out ADDR_W: original byte address of the erroring access.
- `busy_o` out 1: outstanding count ≠ 0, or `data_req_o` is high.
- `data_req_o` out 1: bus request.
- `data_gnt_i` in 1: bus grant.
- `data_rvalid_i` in 1: in-order bus response.
- `data_err_i` in 1: bus error, qualified by `data_rvalid_i`.
- `data_addr_o` out ADDR_W: word-aligned bus address.
- `data_we_o` out 1: bus write enable.
- `data_be_o` out 4: byte enables.
- `data_wdata_o` out 32: lane-aligned write data.
- `data_rdata_i` in 32: read data.

## Operation
Issue FSM states: `ISSUE` (first or only beat) and `SECOND` (second beat of a split).

Misalignment rule:
- Word: misaligned when `addr[1:0]` ≠ 0.
- Half: misaligned when `addr[1:0]` = 3.
- Byte: never misaligned.

Address and byte enables:
- Beat 1 uses `addr & ~3`.
- Beat 2 uses `(addr & ~3) + 4`, wrapping modulo 2^ADDR_W.
- `data_be_o` for beat 1 matches the aligned patterns (word 1111/1110/1100/1000 by offset, half 0011/0110/1100/1000, byte one-hot).
- `data_be_o` for beat 2 is the remaining low lanes (word 0001/0011/0111; half 0001).

Write data: `data_wdata_o` = `lsu_wdata_i` rotated left by 8·`addr[1:0]` bits, on both beats.

Issue sequence:
- In `ISSUE`, `data_req_o` = `lsu_req_i` & (`cnt` < `MAX_OUTST`).
- On grant of an aligned access: `lsu_gnt_o`=1 and the FSM stays in `ISSUE`.
- On grant of a misaligned access: the FSM moves to `SECOND` with `lsu_gnt_o`=0.
- In `SECOND`, `data_req_o` = (`cnt` < `MAX_OUTST`). On grant, `lsu_gnt_o`=1 and the FSM returns to `ISSUE`.

Metadata FIFO:
- Depth `MAX_OUTST`, one entry per granted beat.
- Entry fields: {we, type, offset, sign_ext, part ∈ {single, first, second}, original addr}.
- Pushed on grant, popped on `data_rvalid_i`.
- `cnt` = FIFO occupancy. Grant and response in the same cycle leave `cnt` unchanged.

Response path:
- `single`: `lsu_rvalid_o`=1 in the same cycle. Data is extracted from `data_rdata_i` by offset and type, then zero- or sign-extended.
- `first`: raw `data_rdata_i` and the error bit are latched into a staging register; no `lsu_rvalid_o`.
- `second`: `lsu_rvalid_o`=1. Data = low 32 bits of {`data_rdata_i`, staging} >> 8·offset, then half/word extended.
- `lsu_err_o` = staged error OR current `data_err_i`. `lsu_err_addr_o` = entry's original addr; 0 when `lsu_err_o`=0.

## Timing
- Reset values: all outputs 0, `cnt`=0, FIFO empty, FSM in `ISSUE`, staging register 0.
- Bus-side latency:
  - `data_req_o` is combinational from `lsu_req_i` and registered `cnt`.
  - No combinational path from `data_rvalid_i` to `data_req_o`.
  - A beat freed this cycle enables a new request next cycle.
- Minimum access latency:
  - Aligned access: grant in cycle N, `lsu_rvalid_o` in N+1.
  - Split access: grants in N and N+1 if `MAX_OUTST` ≥ 2; `lsu_rvalid_o` at the second response.
- Throughput: one beat per cycle while `cnt` < `MAX_OUTST`.
- Full (`cnt` = `MAX_OUTST`): `data_req_o`=0 even if `lsu_req_i`=1.
- `data_rvalid_i` with an empty FIFO is ignored, including responses to beats granted before a mid-operation reset.
- Reset during `SECOND` abandons the split; EX must re-request.
- Store responses produce `lsu_rvalid_o` in order, exactly like loads.

## Configuration
- `ZERORISCY_LSU_BUS_ERR_EN` defined:
  - `data_err_i` is sampled and staged as described.
  - `lsu_err_o` and `lsu_err_addr_o` are live.
- `ZERORISCY_LSU_BUS_ERR_EN` undefined:
  - `data_err_i` is ignored.
  - `lsu_err_o`=0 and `lsu_err_addr_o`=0 constantly.
  - No address or error bits are stored in the FIFO or the staging register.

## Test plan
- Aligned LW at 0x100; `data_gnt_i`=1 at cycle 1, rvalid at cycle 2 with rdata 0xDEADBEEF → `data_be_o`=1111, `lsu_gnt_o` at cycle 1, `lsu_rvalid_o` at cycle 2 with `lsu_rdata_o`=0xDEADBEEF.
- LH sign-ext at 0x103; beat 1 rdata 0x80xxxxxx, beat 2 rdata 0xxxxxxxFF → addresses 0x100/0x104, BE 1000/0001, single `lsu_rvalid_o` with rdata 0xFFFFFF80.
- SW 0x11223344 at 0x202 → beat 1 addr 0x200 BE 1100 wdata 0x33441122; beat 2 addr 0x204 BE 0011 same wdata.
- MAX_OUTST=2, four back-to-back LBs with responses delayed 3 cycles → at most 2 grants before the first rvalid; `data_req_o` low at full; results returned in order.
- Misaligned LW with `data_err_i`=1 on beat 1 only (ERR_EN defined) → `lsu_err_o`=1 and `lsu_err_addr_o`=original addr on the second-beat response; with the macro undefined, `lsu_err_o`=0.
- `rst` asserted with 2 beats outstanding, then late rvalids arrive → no `lsu_rvalid_o`, `cnt` stays 0, `busy_o`=0.
